// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state enum and access-size encodings.
package dm_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering for one access: store byte enables and lane
// replication, load byte/halfword extraction with extension, and the
// misalignment / reserved-size error flag.
module dm_lane_align
   import dm_arb_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        sext,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic        err,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   output logic [31:0] load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Decode size/offset into lane enables, replicated store data and extended load data.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
      err        = 1'b0;
      be         = 4'b0000;
      lane_wdata = 32'h0;
      load_data  = 32'h0;
      sel_byte   = mem_rdata[{addr_lo, 3'b000} +: 8];
      sel_half   = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size)
         SZ_BYTE: begin
            be         = 4'b0001 << addr_lo;
            lane_wdata = {4{wdata[7:0]}};
            load_data  = {{24{sext & sel_byte[7]}}, sel_byte};
         end
         SZ_HALF: begin
            err        = addr_lo[0];
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata[15:0]}};
            load_data  = {{16{sext & sel_half[15]}}, sel_half};
         end
         SZ_WORD: begin
            err        = |addr_lo;
            be         = 4'b1111;
            lane_wdata = wdata;
            load_data  = mem_rdata;
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access takes IDLE (grant) -> ISSUE (memory strobe) -> RESP (rvalid).
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [1:0]        m0_size,
   input  logic              m0_sext,
   input  logic [31:0]       m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [1:0]        m1_size,
   input  logic              m1_sext,
   input  logic [31:0]       m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              m1_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   arb_state_e        state_q, state_d;
   logic              ptr_q;      // last granted port
   logic              win;
   logic              take;

   logic              lat_port;
   logic              lat_we;
   logic [1:0]        lat_size;
   logic              lat_sext;
   logic [MEM_AW+1:0] lat_addr;
   logic [31:0]       lat_wdata;

   logic              al_err;
   logic [3:0]        al_be;
   logic [31:0]       al_wdata;
   logic [31:0]       al_load;

   // Address bits above the memory window carry no meaning here.
   logic unused_addr_hi;
   assign unused_addr_hi = ^{m0_addr[31:MEM_AW+2], m1_addr[31:MEM_AW+2]};

   dm_lane_align u_align (
      .size       (lat_size),
      .addr_lo    (lat_addr[1:0]),
      .sext       (lat_sext),
      .wdata      (lat_wdata),
      .mem_rdata  (mem_rdata),
      .err        (al_err),
      .be         (al_be),
      .lane_wdata (al_wdata),
      .load_data  (al_load)
   );

   // Round-robin pick: a lone requester wins; on a tie the port not granted last wins.
   always_comb begin
      win = m1_req;
      if (m0_req && m1_req) win = ~ptr_q;
      take = !reset && (state_q == ST_IDLE) && (m0_req || m1_req);
   end

   // State register and round-robin pointer.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         if (take) ptr_q <= win;
      end
   end

   // Capture the winner's request at grant time for use in ISSUE and RESP.
   always_ff @(posedge clk) begin
      // NOTE: request payload is deliberately not reset; it is only consumed after a fresh grant.
      if (take) begin
         lat_port  <= win;
         lat_we    <= win ? m1_we    : m0_we;
         lat_size  <= win ? m1_size  : m0_size;
         lat_sext  <= win ? m1_sext  : m0_sext;
         lat_addr  <= win ? m1_addr[MEM_AW+1:0] : m0_addr[MEM_AW+1:0];
         lat_wdata <= win ? m1_wdata : m0_wdata;
      end
   end

   // Next-state and all outputs; everything is quiet while reset is held.
   always_comb begin
      state_d   = state_q;
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      m0_err    = 1'b0;
      m1_err    = 1'b0;
      m0_rdata  = 32'h0;
      m1_rdata  = 32'h0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               if (take) begin
                  state_d = ST_ISSUE;
                  if (win) m1_gnt = 1'b1;
                  else     m0_gnt = 1'b1;
               end
            end
            ST_ISSUE: begin
               state_d = ST_RESP;
               if (!al_err) begin
                  mem_en   = 1'b1;
                  mem_we   = lat_we;
                  mem_addr = lat_addr[MEM_AW+1:2];
                  if (lat_we) begin
                     mem_be    = al_be;
                     mem_wdata = al_wdata;
                  end
               end
            end
            ST_RESP: begin
               state_d = ST_IDLE;
               if (lat_port) begin
                  m1_rvalid = 1'b1;
                  m1_err    = al_err;
                  m1_rdata  = (al_err || lat_we) ? 32'h0 : al_load;
               end else begin
                  m0_rvalid = 1'b1;
                  m0_err    = al_err;
                  m0_rdata  = (al_err || lat_we) ? 32'h0 : al_load;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule
